// File: rtl/display_pkg.sv
// Shared constants and state type for the seven-segment display scheduler.
package display_pkg;

    localparam int HEX_W          = 24;
    localparam int DEFAULT_DIGITS = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_t;

endpackage

// File: rtl/display_tick_gen.sv
// Timing base for the display: digit-advance tick, frame boundary and dp blink tick.
module display_tick_gen #(
    parameter int SCAN_DIV     = 50000,
    parameter int DIGITS       = 6,
    parameter int BLINK_FRAMES = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic m_f,
    output logic frame_end,
    output logic dp_f
);

    localparam int PW  = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int DGW = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]  pre_q, pre_d;
    logic [DGW-1:0] digit_q, digit_d;
    logic [BW-1:0]  blink_q, blink_d;

    // The digit counter only moves on m_f, so it tracks the driver's scan position.
    always_comb begin
        m_f       = (pre_q == PW'(SCAN_DIV - 1));
        frame_end = m_f && (digit_q == DGW'(DIGITS - 1));
        dp_f      = frame_end && (blink_q == BW'(BLINK_FRAMES - 1));

        pre_d   = m_f ? '0 : pre_q + PW'(1);
        digit_d = digit_q;
        blink_d = blink_q;
        if (m_f) begin
            digit_d = frame_end ? '0 : digit_q + DGW'(1);
        end
        if (frame_end) begin
            blink_d = dp_f ? '0 : blink_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            digit_q <= '0;
            blink_q <= '0;
        end else begin
            pre_q   <= pre_d;
            digit_q <= digit_d;
            blink_q <= blink_d;
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Shares the display driver among NREQ requesters, round-robin with dwell, switching only on frame boundaries.
module display_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DIGITS       = DEFAULT_DIGITS,
    parameter int DWELL_FRAMES = 200,
    parameter int BLINK_FRAMES = 50,
    parameter int NREQ         = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [HEX_W*NREQ-1:0]   data,
    input  logic                    lock,
    output logic                    m_f,
    output logic                    dp_f,
    output logic [HEX_W-1:0]        hex,
    output logic [NREQ-1:0]         grant,
    output logic                    frame_end
);

    localparam int IW = $clog2(NREQ);
    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    disp_state_t      state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [HEX_W-1:0] hex_q, hex_d;
    logic [IW-1:0]    next_idx;
    logic             any_req;
    logic             rotate;

    display_tick_gen #(
        .SCAN_DIV     (SCAN_DIV),
        .DIGITS       (DIGITS),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_f       (m_f),
        .frame_end (frame_end),
        .dp_f      (dp_f)
    );

    // Search starts after ptr, so the current owner is the last candidate considered.
    function automatic logic [IW-1:0] rr_next(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] sel;
        logic          found;
        logic [IW-1:0] cand;
        sel   = p;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(p) + k) % NREQ);
            if (!found && r[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        dwell_d  = dwell_q;
        grant_d  = grant_q;
        hex_d    = hex_q;
        any_req  = |req;
        next_idx = rr_next(req, ptr_q);
        rotate   = (dwell_q == DW'(DWELL_FRAMES - 1)) || !req[owner_q];

        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_d = SHOW;
                        owner_d = next_idx;
                        ptr_d   = next_idx;
                        dwell_d = '0;
                    end
                end
                SHOW: begin
                    if (!rotate) begin
                        dwell_d = dwell_q + DW'(1);
                    end else if (lock && req[owner_q]) begin
                        dwell_d = '0;
                    end else if (any_req) begin
                        owner_d = next_idx;
                        ptr_d   = next_idx;
                        dwell_d = '0;
                    end else begin
                        state_d = IDLE;
                        dwell_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase

            // hex is re-snapshotted every frame so a frame never shows mid-update data.
            if (state_d == SHOW) begin
                grant_d = NREQ'(1) << owner_d;
                hex_d   = data[HEX_W*int'(owner_d) +: HEX_W];
            end else begin
                grant_d = '0;
                hex_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IW'(NREQ - 1);
            dwell_q <= '0;
            grant_q <= '0;
            hex_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            grant_q <= grant_d;
            hex_q   <= hex_d;
        end
    end

    assign grant = grant_q;
    assign hex   = hex_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with SCAN_DIV=4, DIGITS=6, DWELL_FRAMES=2, BLINK_FRAMES=3, NREQ=4.
module tb_display_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [95:0] data;
    logic        lock;
    logic        m_f;
    logic        dp_f;
    logic [23:0] hex;
    logic [3:0]  grant;
    logic        frame_end;

    int checks;
    int failures;

    display_scheduler #(
        .SCAN_DIV     (4),
        .DIGITS       (6),
        .DWELL_FRAMES (2),
        .BLINK_FRAMES (3),
        .NREQ         (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
        .lock      (lock),
        .m_f       (m_f),
        .dp_f      (dp_f),
        .hex       (hex),
        .grant     (grant),
        .frame_end (frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Leaves the bench on the negedge where frame_end is high.
    task automatic wait_frame_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_end) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL frame_end_timeout actual=none_in_100_cycles required=frame_end");
        end
    endtask

    task automatic test_reset();
        bit exp_m, exp_fe, exp_dp;
        req   = 4'b0000;
        lock  = 1'b0;
        data  = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks += 5;
        if (m_f !== 1'b0)       begin failures++; $display("[TB] FAIL reset_m_f actual=%b required=0", m_f); end
        if (dp_f !== 1'b0)      begin failures++; $display("[TB] FAIL reset_dp_f actual=%b required=0", dp_f); end
        if (frame_end !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_end actual=%b required=0", frame_end); end
        if (grant !== 4'h0)     begin failures++; $display("[TB] FAIL reset_grant actual=%h required=0", grant); end
        if (hex !== 24'h0)      begin failures++; $display("[TB] FAIL reset_hex actual=%h required=0", hex); end
        rst_n = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            exp_m  = (c % 4) == 3;
            exp_fe = (c % 24) == 23;
            exp_dp = (c % 72) == 71;
            checks += 5;
            if (m_f !== exp_m)       begin failures++; $display("[TB] FAIL idle_m_f c=%0d actual=%b required=%b", c, m_f, exp_m); end
            if (frame_end !== exp_fe) begin failures++; $display("[TB] FAIL idle_frame_end c=%0d actual=%b required=%b", c, frame_end, exp_fe); end
            if (dp_f !== exp_dp)     begin failures++; $display("[TB] FAIL idle_dp_f c=%0d actual=%b required=%b", c, dp_f, exp_dp); end
            if (grant !== 4'h0)      begin failures++; $display("[TB] FAIL idle_grant c=%0d actual=%h required=0", c, grant); end
            if (hex !== 24'h0)       begin failures++; $display("[TB] FAIL idle_hex c=%0d actual=%h required=0", c, hex); end
        end
    endtask

    task automatic test_single();
        req  = 4'b0001;
        data = {24'h0, 24'h0, 24'h0, 24'h123456};
        wait_frame_end();
        checks++;
        if (grant !== 4'h0) begin failures++; $display("[TB] FAIL single_pre_grant actual=%h required=0", grant); end
        @(negedge clk);
        checks += 2;
        if (grant !== 4'b0001)   begin failures++; $display("[TB] FAIL single_grant actual=%b required=0001", grant); end
        if (hex !== 24'h123456)  begin failures++; $display("[TB] FAIL single_hex actual=%h required=123456", hex); end
        data[23:0] = 24'hABCDEF;
        repeat (5) @(negedge clk);
        checks++;
        if (hex !== 24'h123456) begin failures++; $display("[TB] FAIL single_snapshot actual=%h required=123456", hex); end
        wait_frame_end();
        @(negedge clk);
        checks += 2;
        if (hex !== 24'hABCDEF) begin failures++; $display("[TB] FAIL single_resample actual=%h required=abcdef", hex); end
        if (grant !== 4'b0001)  begin failures++; $display("[TB] FAIL single_hold0 actual=%b required=0001", grant); end
        for (int f = 1; f <= 3; f++) begin
            wait_frame_end();
            @(negedge clk);
            checks++;
            if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL single_hold%0d actual=%b required=0001", f, grant); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [23:0] exp_h [5] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h111111};
        req  = 4'b1111;
        lock = 1'b0;
        data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            wait_frame_end();
            @(negedge clk);
            checks += 2;
            if (grant !== exp_g[s]) begin failures++; $display("[TB] FAIL rr_grant step=%0d actual=%b required=%b", s, grant, exp_g[s]); end
            if (hex !== exp_h[s])   begin failures++; $display("[TB] FAIL rr_hex step=%0d actual=%h required=%h", s, hex, exp_h[s]); end
            wait_frame_end();
            @(negedge clk);
            if (s < 4) begin
                checks++;
                if (grant !== exp_g[s]) begin failures++; $display("[TB] FAIL rr_dwell step=%0d actual=%b required=%b", s, grant, exp_g[s]); end
            end
        end
    endtask

    task automatic test_lock();
        req  = 4'b1111;
        lock = 1'b0;
        data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        do_reset();
        repeat (3) wait_frame_end();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL lock_setup actual=%b required=0010", grant); end
        lock = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            wait_frame_end();
            @(negedge clk);
            checks++;
            if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL lock_hold frame=%0d actual=%b required=0010", f, grant); end
        end
        lock = 1'b0;
        wait_frame_end();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL unlock_dwell actual=%b required=0010", grant); end
        wait_frame_end();
        @(negedge clk);
        checks += 2;
        if (grant !== 4'b0100) begin failures++; $display("[TB] FAIL unlock_rotate actual=%b required=0100", grant); end
        if (hex !== 24'h333333) begin failures++; $display("[TB] FAIL unlock_hex actual=%h required=333333", hex); end
    endtask

    task automatic test_drop();
        req  = 4'b0011;
        lock = 1'b0;
        data = {24'h0, 24'h0, 24'hBEEF02, 24'hCAFE01};
        do_reset();
        wait_frame_end();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL drop_setup actual=%b required=0001", grant); end
        repeat (9) @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL drop_no_early actual=%b required=0001", grant); end
        wait_frame_end();
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL drop_at_frame_end actual=%b required=0001", grant); end
        @(negedge clk);
        checks += 2;
        if (grant !== 4'b0010)  begin failures++; $display("[TB] FAIL drop_next actual=%b required=0010", grant); end
        if (hex !== 24'hBEEF02) begin failures++; $display("[TB] FAIL drop_next_hex actual=%h required=beef02", hex); end
        repeat (10) @(negedge clk);
        req = 4'b0000;
        wait_frame_end();
        checks++;
        if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL drop_last_hold actual=%b required=0010", grant); end
        @(negedge clk);
        checks += 2;
        if (grant !== 4'h0) begin failures++; $display("[TB] FAIL drop_idle_grant actual=%b required=0000", grant); end
        if (hex !== 24'h0)  begin failures++; $display("[TB] FAIL drop_idle_hex actual=%h required=000000", hex); end
    endtask

    task automatic test_mid_reset();
        bit exp_m;
        req  = 4'b1111;
        lock = 1'b0;
        data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        do_reset();
        repeat (3) wait_frame_end();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL mreset_setup actual=%b required=0010", grant); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (grant !== 4'h0) begin failures++; $display("[TB] FAIL mreset_grant actual=%b required=0000", grant); end
        if (hex !== 24'h0)  begin failures++; $display("[TB] FAIL mreset_hex actual=%h required=000000", hex); end
        if ({m_f, dp_f, frame_end} !== 3'b000) begin failures++; $display("[TB] FAIL mreset_ticks actual=%b required=000", {m_f, dp_f, frame_end}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            exp_m = (c % 4) == 3;
            checks++;
            if (m_f !== exp_m) begin failures++; $display("[TB] FAIL mreset_m_f c=%0d actual=%b required=%b", c, m_f, exp_m); end
            if (c == 23) begin
                checks += 2;
                if (frame_end !== 1'b1) begin failures++; $display("[TB] FAIL mreset_frame_end actual=%b required=1", frame_end); end
                if (grant !== 4'h0)     begin failures++; $display("[TB] FAIL mreset_pre_grant actual=%b required=0000", grant); end
            end
            if (c == 24) begin
                checks += 2;
                if (grant !== 4'b0001)  begin failures++; $display("[TB] FAIL mreset_first_grant actual=%b required=0001", grant); end
                if (hex !== 24'h111111) begin failures++; $display("[TB] FAIL mreset_first_hex actual=%h required=111111", hex); end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_drop();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
